alu_ctrl_seq: RTL
=================

# alu_ctrl_seq

Sequenced ALU control unit for the MIPS datapath: decodes `alu_op`/`funct` into the 4-bit ALU control code and runs multi-cycle multiply/divide. It holds the control code and asserts `busy` for a parameterised number of cycles, so the pipeline stalls until the result is ready. It sits between the main control unit (source of `alu_op`) and the ALU/multiply-divide unit. Single-cycle operations pass through with one cycle of registered latency.

## Interface
Parameters:
- `MUL_CYCLES`, 4: cycles the multiplier needs; ≥1.
- `DIV_CYCLES`, 8: cycles the divider needs; ≥1.
- `CNT_W`, `$clog2(max(MUL_CYCLES,DIV_CYCLES)+1)`: width of the countdown counter; derived, not overridden.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `op_valid` in 1: `alu_op`/`funct` are presented this cycle.
- `alu_op` in 3: operation class from main control.
- `funct` in 6: R-type function field.
- `flush` in 1: abort any in-flight multi-cycle op.
- `op_ready` out 1: block can accept an op; equals `~busy & ~flush`.
- `alu_control` out 4: registered ALU control code.
- `ctrl_valid` out 1: one-cycle pulse; `alu_control` is newly loaded.
- `busy` out 1: multi-cycle op in progress; drives pipeline stall.
- `multi_done` out 1: one-cycle pulse in the final cycle of a multi-cycle op.
- `illegal` out 1: one-cycle pulse with `ctrl_valid` when the decode is illegal.

## Operation
- Accept condition: `op_valid & op_ready` sampled at a rising edge.
- Decode by `alu_op`:
  - 000 → 0011 (add)
  - 001 → 0010 (sub)
  - 011 → 0110 (bne)
  - 100 → 0111 (bgt)
  - 101 → 1000 (blt)
  - 110, 111 → 1111 (illegal)
- Decode by `funct` when `alu_op` = 010:
  - 100000 → 0000 (div)
  - 000001 → 0001 (mul)
  - 000010 → 0010 (sub)
  - 000011 → 0011 (add)
  - 000100 → 0100 (or)
  - 000101 → 0101 (and)
  - any other → 1111 (illegal)
- States and transitions:
  - IDLE: accept of a single-cycle or illegal op loads `alu_control` and stays in IDLE.
  - IDLE → MUL_RUN: accept of mul; counter loads `MUL_CYCLES-1`.
  - IDLE → DIV_RUN: accept of div; counter loads `DIV_CYCLES-1`.
  - MUL_RUN/DIV_RUN: counter decrements each edge. `multi_done`=1 combinationally while the counter is 0. The next edge returns to IDLE.
- `alu_control` holds its value until the next accept; during a RUN state it stays 0001 or 0000.
- An illegal op never enters a RUN state and never asserts `busy`.
- `flush` high at an edge: RUN → IDLE, counter cleared, no `multi_done` for the aborted op. An op presented in the same cycle is not accepted (`op_ready` is low).

## Timing
- Reset: state IDLE, `alu_control`=1111, `ctrl_valid`=0, `busy`=0, `multi_done`=0, `illegal`=0, counter 0. Reset during a RUN state aborts it silently.
- All accepts (latency 1): accept at edge N → `alu_control`/`ctrl_valid`/`illegal` valid in cycle N+1.
- Single-cycle op: `op_ready` stays high, so back-to-back accepts are allowed every cycle.
- Multi-cycle op accepted at edge N:
  - `busy`=1 in cycles N+1 … N+L, where L is `MUL_CYCLES` or `DIV_CYCLES`.
  - `multi_done`=1 in cycle N+L.
  - `op_ready` is high again in cycle N+L+1.
  - With L=1, `busy` and `multi_done` are both asserted in cycle N+1 only.
- `op_valid` while busy: ignored, not queued; the upstream stage must hold the op.

## Configuration
- `ALU_CTRL_DIV_EN` defined: divide is supported as above (0000, DIV_RUN, `DIV_CYCLES`).
- `ALU_CTRL_DIV_EN` undefined:
  - `funct` 100000 decodes to 1111 with `illegal` pulsed.
  - DIV_RUN state and `DIV_CYCLES` have no effect; `CNT_W` is derived from `MUL_CYCLES` only.

## Structure
- Package `alu_ctrl_pkg` holds:
  - `alu_op` class constants;
  - `funct` constants;
  - the 4-bit control-code constants, including `ALU_ILLEGAL`=1111;
  - the state enum.
- One sub-module, `alu_ctrl_decode`, is purely combinational: `alu_op`/`funct` → {code, is_mul, is_div, is_illegal}. The top level holds the state machine, counter and output registers.

## Test plan
- Reset with `rst_n`=0 for 2 cycles → `alu_control`=1111, `busy`=0, `ctrl_valid`=0, `op_ready`=1.
- `alu_op`=000, then 010/000100 on consecutive cycles → `ctrl_valid` in both following cycles, `alu_control`=0011 then 0100, `busy` never asserted.
- Mul with `MUL_CYCLES`=4 accepted at edge N → `busy` in cycles N+1..N+4, `multi_done` only in N+4; an op held on `op_valid` during that window is accepted at edge N+5.
- Div accepted, `flush` asserted 2 cycles later → `busy` low the cycle after flush, no `multi_done`, `alu_control` stays 0000. With `ALU_CTRL_DIV_EN` undefined: the same div → 1111 with `illegal`=1, no `busy`.
- `alu_op`=111 and `alu_op`=010/111111 → 1111 with `illegal` pulse, no `busy`.
- `rst_n` low mid-MUL_RUN → next cycle `busy`=0, `alu_control`=1111, no `multi_done`.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants for the sequenced ALU control unit.
// Holds the alu_op operation classes, the R-type funct codes, the 4-bit
// ALU control codes and the sequencer state encoding.
package alu_ctrl_pkg;

    // Operation classes driven by the main control unit
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_BNE   = 3'b011;
    localparam logic [2:0] OP_BGT   = 3'b100;
    localparam logic [2:0] OP_BLT   = 3'b101;

    // R-type function field values recognised when alu_op selects R-type
    localparam logic [5:0] FN_DIV = 6'b100000;
    localparam logic [5:0] FN_MUL = 6'b000001;
    localparam logic [5:0] FN_SUB = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b000011;
    localparam logic [5:0] FN_OR  = 6'b000100;
    localparam logic [5:0] FN_AND = 6'b000101;

    // ALU control codes presented to the ALU / multiply-divide unit
    localparam logic [3:0] ALU_DIV     = 4'b0000;
    localparam logic [3:0] ALU_MUL     = 4'b0001;
    localparam logic [3:0] ALU_SUB     = 4'b0010;
    localparam logic [3:0] ALU_ADD     = 4'b0011;
    localparam logic [3:0] ALU_OR      = 4'b0100;
    localparam logic [3:0] ALU_AND     = 4'b0101;
    localparam logic [3:0] ALU_BNE     = 4'b0110;
    localparam logic [3:0] ALU_BGT     = 4'b0111;
    localparam logic [3:0] ALU_BLT     = 4'b1000;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    // Sequencer states: idle, or counting down a multiply / divide
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: purely combinational decode of alu_op/funct into the
// 4-bit ALU control code plus multi-cycle and illegal classification.
// Divide support is enabled by defining ALU_CTRL_DIV_EN; without it the
// divide funct decodes as illegal and is_div is never raised.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] code,
    output logic       is_mul,
    output logic       is_div,
    output logic       is_illegal
);

    // Map the operation class (and funct for R-type) to a control code
    always_comb begin
        code   = ALU_ILLEGAL;
        is_mul = 1'b0;
        is_div = 1'b0;
        case (alu_op)
            OP_ADD:   code = ALU_ADD;
            OP_SUB:   code = ALU_SUB;
            OP_BNE:   code = ALU_BNE;
            OP_BGT:   code = ALU_BGT;
            OP_BLT:   code = ALU_BLT;
            OP_RTYPE: begin
                case (funct)
                    FN_DIV: begin
`ifdef ALU_CTRL_DIV_EN
                        code   = ALU_DIV;
                        is_div = 1'b1;
`else
                        code   = ALU_ILLEGAL;
`endif
                    end
                    FN_MUL: begin
                        code   = ALU_MUL;
                        is_mul = 1'b1;
                    end
                    FN_SUB:  code = ALU_SUB;
                    FN_ADD:  code = ALU_ADD;
                    FN_OR:   code = ALU_OR;
                    FN_AND:  code = ALU_AND;
                    default: code = ALU_ILLEGAL;
                endcase
            end
            default: code = ALU_ILLEGAL;
        endcase
        is_illegal = (code == ALU_ILLEGAL);
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: sequenced ALU control unit. Registers the decoded ALU
// control code with one cycle of latency and, for multiply/divide, holds
// busy high for MUL_CYCLES / DIV_CYCLES cycles so the pipeline stalls.
// Divide support is enabled by defining ALU_CTRL_DIV_EN.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    input  logic [2:0] alu_op,
    input  logic [5:0] funct,
    input  logic       flush,
    output logic       op_ready,
    output logic [3:0] alu_control,
    output logic       ctrl_valid,
    output logic       busy,
    output logic       multi_done,
    output logic       illegal
);

`ifdef ALU_CTRL_DIV_EN
    localparam int CNT_SPAN = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
`else
    localparam int CNT_SPAN = MUL_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_SPAN + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    // Without divide support the decoder never raises is_div, so this load
    // value is unreachable even if it does not fit the narrower counter.
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             ctrl_valid_q, ctrl_valid_d;
    logic             illegal_q, illegal_d;

    logic [3:0] dec_code;
    logic       dec_is_mul;
    logic       dec_is_div;
    logic       dec_is_illegal;
    logic       accept;

    alu_ctrl_decode u_decode (
        .alu_op     (alu_op),
        .funct      (funct),
        .code       (dec_code),
        .is_mul     (dec_is_mul),
        .is_div     (dec_is_div),
        .is_illegal (dec_is_illegal)
    );

    assign busy        = (state_q != ST_IDLE);
    assign op_ready    = ~busy & ~flush;
    assign accept      = op_valid & op_ready;
    // A flushed op must not report completion, even on its last cycle
    assign multi_done  = busy & (cnt_q == '0) & ~flush;
    assign alu_control = ctrl_q;
    assign ctrl_valid  = ctrl_valid_q;
    assign illegal     = illegal_q;

    // Next-state, countdown and output-register load logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl_d       = ctrl_q;
        ctrl_valid_d = 1'b0;
        illegal_d    = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ctrl_d       = dec_code;
                        ctrl_valid_d = 1'b1;
                        illegal_d    = dec_is_illegal;
                        if (dec_is_mul) begin
                            state_d = ST_MUL_RUN;
                            cnt_d   = MUL_LOAD;
                        end else if (dec_is_div) begin
                            state_d = ST_DIV_RUN;
                            cnt_d   = DIV_LOAD;
                        end
                    end
                end
                ST_MUL_RUN, ST_DIV_RUN: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ctrl_q       <= ALU_ILLEGAL;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_q       <= ctrl_d;
            ctrl_valid_q <= ctrl_valid_d;
            illegal_q    <= illegal_d;
        end
    end

endmodule
